// File: rtl/round_share_pkg.sv
// Shared types and helpers for the round-robin shared rounding block.
package round_share_pkg;

   localparam int MAX_CH = 16;
   localparam int MAX_W  = 64;

   typedef logic [$clog2(MAX_CH)-1:0] ch_tag_t;

   // Tag width for n channels; a single channel still needs one bit.
   function automatic int ch_w_calc(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Round-half-to-even on an unsigned word; callers keep the low DIN bits,
   // which gives the modulo-2^DIN wrap for free.
   function automatic logic [MAX_W-1:0] rte_calc(input logic [MAX_W-1:0] x,
                                                 input int unsigned nbits);
      logic [MAX_W-1:0] s;
      s = x + ((MAX_W'(1) << (nbits - 1)) - MAX_W'(1)) + MAX_W'(x[nbits[5:0]]);
      return s & ~((MAX_W'(1) << nbits) - MAX_W'(1));
   endfunction

endpackage

// File: rtl/round_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
   import round_share_pkg::*;
#(
   parameter  int N    = 3,
   localparam int CH_W = ch_w_calc(N)
) (
   input  logic [N-1:0]    req,
   input  logic [CH_W-1:0] ptr,
   output logic [N-1:0]    gnt_oh,
   output logic [CH_W-1:0] gnt_idx,
   output logic            any
);

   always_comb begin
      int unsigned idx;
      idx     = 0;
      gnt_oh  = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr) + k) % N;
         if (!any && req[idx]) begin
            any         = 1'b1;
            gnt_oh[idx] = 1'b1;
            gnt_idx     = CH_W'(idx);
         end
      end
   end

endmodule

// File: rtl/round_share_arb.sv
// Shares one round-half-to-even stage between NUM_CH requesters through a
// single tagged output register.
module round_share_arb
   import round_share_pkg::*;
#(
   parameter  int NUM_CH = 3,
   parameter  int DIN    = 16,
   parameter  int NBITS  = 4,
   localparam int CH_W   = ch_w_calc(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH*DIN-1:0] din_data,
   input  logic [NUM_CH-1:0]     din_valid,
   output logic [NUM_CH-1:0]     din_ready,
   output logic [NUM_CH*DIN-1:0] dout_data,
   output logic [NUM_CH-1:0]     dout_valid,
   input  logic [NUM_CH-1:0]     dout_ready,
   output logic                  busy
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [CH_W-1:0] ptr;
   logic            out_vld;
   logic [DIN-1:0]  out_data;
   logic [CH_W-1:0] out_tag;

   logic [NUM_CH-1:0] gnt_oh;
   logic [CH_W-1:0]   gnt_idx;
   logic              any;
   logic              drain;
   logic              can_accept;
   logic              accept;
   logic [DIN-1:0]    sel_word;
   logic [DIN-1:0]    rnd;

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .req     (din_valid),
      .ptr     (ptr),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   assign drain      = (out_vld == ST_FULL) && dout_ready[out_tag];
   assign can_accept = (out_vld == ST_EMPTY) || drain;
   assign accept     = can_accept && any && !rst;
   // rst gates din_ready so a word offered during reset is never seen as taken.
   assign din_ready  = (can_accept && !rst) ? gnt_oh : '0;

   always_comb begin
      sel_word = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (gnt_oh[i]) sel_word = din_data[i*DIN +: DIN];
      end
   end

   assign rnd = DIN'(rte_calc(MAX_W'(sel_word), NBITS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         out_vld  <= ST_EMPTY;
         out_data <= '0;
         out_tag  <= '0;
      end else if (accept) begin
         out_data <= rnd;
         out_tag  <= gnt_idx;
         out_vld  <= ST_FULL;
         ptr      <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end else if (drain) begin
         out_vld  <= ST_EMPTY;
      end
   end

   always_comb begin
      dout_valid = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         dout_valid[i] = (out_vld == ST_FULL) && (out_tag == CH_W'(i));
      end
   end

   assign dout_data = {NUM_CH{out_data}};
   assign busy      = out_vld;

endmodule
